// File: rtl/spi_regbank_if.sv
// rtl/spi_regbank_if.sv - SPI pin and channel-bus bundle for spi_regbank
// Signals: SCK/SSEL/MOSI/MISO SPI pins; rd_data flattened channel read bus (channel i at [i*DW +: DW]);
//          wr_data write payload; pwm_wen/quad_wen one-hot write strobes; frame_err reject pulse.
// Modports: slave (the register bank), master (SPI host plus channel arrays).
interface spi_regbank_if #(
   parameter int NCH = 8,
   parameter int DW  = 16
);
   logic              SCK;
   logic              SSEL;
   logic              MOSI;
   logic              MISO;
   logic [NCH*DW-1:0] rd_data;
   logic [DW-1:0]     wr_data;
   logic [NCH-1:0]    pwm_wen;
   logic [NCH-1:0]    quad_wen;
   logic              frame_err;

   modport slave (
      input  SCK, SSEL, MOSI, rd_data,
      output MISO, wr_data, pwm_wen, quad_wen, frame_err
   );

   modport master (
      output SCK, SSEL, MOSI, rd_data,
      input  MISO, wr_data, pwm_wen, quad_wen, frame_err
   );
endinterface

// File: rtl/spi_regbank.sv
// rtl/spi_regbank.sv - SPI mode-0 slave register front end for the PWM/quadrature channel arrays
// Ports: CLK system clock; RST asynchronous active-low reset;
//        bus (spi_regbank_if.slave): SPI pins in, registered MISO out, channel read bus in,
//        wr_data payload, pwm_wen/quad_wen one-cycle one-hot strobes, frame_err reject pulse.
module spi_regbank #(
   parameter int          NCH       = 8,
   parameter int          DW        = 16,
   parameter logic [15:0] SERIAL_ID = 16'hAABB
) (
   input logic          CLK,
   input logic          RST,
   spi_regbank_if.slave bus
);
   localparam int              FRAME_BITS = 8 + DW;
   localparam int              CW         = $clog2(FRAME_BITS + 2);
   localparam int              DBW        = $clog2(DW);
   localparam logic [CW-1:0]   CNT_FRAME  = CW'(FRAME_BITS);
   localparam logic [CW-1:0]   CNT_MAX    = CW'(FRAME_BITS + 1);
   localparam logic [CW-1:0]   CNT_CMD    = CW'(7);
   localparam logic [DBW-1:0]  DBIT_LAST  = DBW'(DW - 1);
   localparam logic [5:0]      ADDR_STAT  = 6'h3E;
   localparam logic [5:0]      ADDR_ID    = 6'h3F;
   localparam logic [5:0]      LAST_CH    = 6'(NCH - 1);

   typedef enum logic [1:0] {IDLE, CMD, DATA, DRAIN} state_t;
   state_t state_q, state_d;

   logic [1:0]     sck_sync, ssel_sync, mosi_sync;
   logic           sck_q, ssel_q;
   logic           sck_s, ssel_s, mosi_s;
   logic           sck_rise, sck_fall, ssel_rise, ssel_fall;

   logic [CW-1:0]  bit_cnt;
   logic [DBW-1:0] dbit;
   logic [6:0]     cmd_sh;
   logic           is_wr, tgt_quad;
   logic [5:0]     addr, cmd_addr, next_addr;
   logic [DW-1:0]  in_sh, out_sh, word_hold;
   logic [7:0]     err_cnt;
   logic           miso_q, err_q;
   logic [DW-1:0]  wr_data_q;
   logic [NCH-1:0] pwm_q, quad_q;

   // Synchronisers reset to "SSEL active" so that releasing reset with SSEL low
   // never looks like a fresh falling edge; IDLE then falls through to DRAIN.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sck_sync  <= '0;
         ssel_sync <= '0;
         mosi_sync <= '0;
         sck_q     <= 1'b0;
         ssel_q    <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[0], bus.SCK};
         ssel_sync <= {ssel_sync[0], bus.SSEL};
         mosi_sync <= {mosi_sync[0], bus.MOSI};
         sck_q     <= sck_sync[1];
         ssel_q    <= ssel_sync[1];
      end
   end

   assign sck_s     = sck_sync[1];
   assign ssel_s    = ssel_sync[1];
   assign mosi_s    = mosi_sync[1];
   assign sck_rise  = sck_s & ~sck_q;
   assign sck_fall  = ~sck_s & sck_q;
   assign ssel_rise = ssel_s & ~ssel_q;
   assign ssel_fall = ~ssel_s & ssel_q;

   // Address as it will be once the 8th bit is shifted in.
   assign cmd_addr  = {cmd_sh[4:0], mosi_s};
   assign next_addr = (addr == LAST_CH) ? 6'd0 : addr + 6'd1;

   function automatic logic [DW-1:0] read_word(input logic [5:0] a, input logic [7:0] cnt,
                                                input logic [NCH*DW-1:0] rd);
      logic [DW-1:0] w;
      w = '0;
      if (a == ADDR_ID) begin
         w = DW'(SERIAL_ID);
      end else if (a == ADDR_STAT) begin
         w = DW'(cnt);
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (int'(a) == i) w = rd[i*DW +: DW];
         end
      end
      return w;
   endfunction

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (ssel_fall)   state_d = CMD;
            else if (!ssel_s) state_d = DRAIN;
         end
         CMD: begin
            if (ssel_rise)                          state_d = IDLE;
            else if (sck_rise && bit_cnt == CNT_CMD) state_d = DATA;
         end
         DATA:    if (ssel_rise) state_d = IDLE;
         DRAIN:   if (ssel_s)    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         bit_cnt   <= '0;
         dbit      <= '0;
         cmd_sh    <= '0;
         is_wr     <= 1'b0;
         tgt_quad  <= 1'b0;
         addr      <= '0;
         in_sh     <= '0;
         out_sh    <= '0;
         word_hold <= '0;
         err_cnt   <= '0;
         miso_q    <= 1'b0;
         err_q     <= 1'b0;
         wr_data_q <= '0;
         pwm_q     <= '0;
         quad_q    <= '0;
      end else begin
         pwm_q  <= '0;
         quad_q <= '0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE, DRAIN: begin
               miso_q <= 1'b0;
               if (state_q == IDLE && ssel_fall) begin
                  bit_cnt <= '0;
                  cmd_sh  <= '0;
                  in_sh   <= '0;
               end
            end
            CMD: begin
               if (!ssel_rise && sck_rise) begin
                  bit_cnt <= bit_cnt + CW'(1);
                  cmd_sh  <= {cmd_sh[5:0], mosi_s};
                  if (bit_cnt == CNT_CMD) begin
                     is_wr    <= cmd_sh[6];
                     tgt_quad <= cmd_sh[5];
                     addr     <= cmd_addr;
                     dbit     <= '0;
                     if (!cmd_sh[6]) begin
                        out_sh    <= read_word(cmd_addr, err_cnt, bus.rd_data);
                        word_hold <= read_word(cmd_addr, err_cnt, bus.rd_data);
                        if (cmd_addr == ADDR_STAT) err_cnt <= '0;
                     end
                  end
               end
            end
            DATA: begin
               if (ssel_rise) begin
                  miso_q <= 1'b0;
                  if (is_wr) begin
                     if (bit_cnt == CNT_FRAME && int'(addr) < NCH) begin
                        wr_data_q <= in_sh;
                        if (tgt_quad) quad_q <= NCH'(1) << addr;
                        else          pwm_q  <= NCH'(1) << addr;
                     end else begin
                        err_q <= 1'b1;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                     end
                  end
               end else begin
                  if (sck_rise) begin
                     if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CW'(1);
                     if (is_wr) begin
                        in_sh <= {in_sh[DW-2:0], mosi_s};
                     end else if (dbit == DBIT_LAST) begin
                        // Word boundary: channel reads step to the next channel,
                        // ID/status reads replay the word captured at command time.
                        dbit <= '0;
                        if (int'(addr) < NCH) begin
                           addr   <= next_addr;
                           out_sh <= read_word(next_addr, err_cnt, bus.rd_data);
                        end else begin
                           out_sh <= word_hold;
                        end
                     end else begin
                        dbit <= dbit + DBW'(1);
                     end
                  end
                  if (sck_fall && !is_wr) begin
                     miso_q <= out_sh[DW-1];
                     out_sh <= {out_sh[DW-2:0], 1'b0};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.MISO      = miso_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.pwm_wen   = pwm_q;
   assign bus.quad_wen  = quad_q;
   assign bus.frame_err = err_q;
endmodule
